tdc_hist_peak: RTL and testbench

Parametrised histogram peak detector for the TDC/ToF datapath. It accumulates per-bin hit counts from a valid/ready sample stream over a frame. The frame closes on a programmable sample count or an explicit flush. The block then scans the histogram sequentially and presents the peak bin, peak count, frame sample count and a saturation flag on a valid/ready output, clearing the histogram on the output handshake. It generalises the fixed 16-bin, 4-bit peak counter to arbitrary bin and count widths, and adds frame control, input back-pressure, saturation and a deterministic tie rule.

---
 rtl/tdc_hist_peak.sv | 172 +++++++++++++++++
 tb/tb_tdc_hist_peak.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hist_peak.sv
// Histogram peak detector.
// Samples arriving on a valid/ready stream are binned into NBINS saturating
// counters. A frame closes on a programmable sample count or on a flush.
// The block then walks the bins one per cycle, keeping the strictly-greater
// maximum so that ties go to the lowest index. It presents the result on a
// valid/ready output and clears the histogram on the output handshake.
module tdc_hist_peak #(
  parameter int BIN_W = 4,
  parameter int CNT_W = 13,
  parameter int FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  input  logic             flush,
  input  logic [FRM_W-1:0] frame_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] peak_bin,
  output logic [CNT_W-1:0] peak_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             sat_flag
);

  localparam int NBINS = 1 << BIN_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FRM_W-1:0] FRM_MAX  = '1;
  localparam logic [BIN_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_OUT} state_t;

  state_t r_state;
  state_t w_state_next;

  // Frame bookkeeping
  logic [FRM_W-1:0] r_frm_cnt;
  logic             r_sat;

  // Scan bookkeeping
  logic [BIN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_best;
  logic [BIN_W-1:0] r_best_bin;

  // Result registers, held until the next frame's scan completes
  logic [BIN_W-1:0] r_peak_bin;
  logic [CNT_W-1:0] r_peak_cnt;
  logic [FRM_W-1:0] r_frame_cnt;

  logic             w_accept;
  logic             w_out_hs;
  logic             w_hit_sat;
  logic [FRM_W-1:0] w_frm_inc;
  logic             w_len_hit;
  logic             w_take;
  logic [CNT_W-1:0] w_best_cnt;
  logic [BIN_W-1:0] w_best_bin;
  logic             w_scan_done;
  logic [CNT_W-1:0] w_hist [NBINS];

  assign in_ready  = (r_state == ST_ACC) & ~rst;
  assign out_valid = (r_state == ST_OUT);
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;

  // Frame counter saturates; a saturated counter only matches a frame_len
  // equal to the maximum, otherwise the frame needs a flush to close.
  assign w_frm_inc = (r_frm_cnt == FRM_MAX) ? r_frm_cnt : r_frm_cnt + 1'b1;
  assign w_len_hit = w_accept && (frame_len != '0) && (w_frm_inc == frame_len);
  assign w_hit_sat = w_accept && (w_hist[in_bin] == CNT_MAX);

  // Strict comparison keeps the earliest (lowest-index) bin on ties.
  assign w_take      = (w_hist[r_idx] > r_best);
  assign w_best_cnt  = w_take ? w_hist[r_idx] : r_best;
  assign w_best_bin  = w_take ? r_idx : r_best_bin;
  assign w_scan_done = (r_idx == IDX_LAST);

  generate
    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
      logic [CNT_W-1:0] r_cnt;
      logic             w_hit;

      assign w_hit = w_accept && (in_bin == BIN_W'(gi));

      // Per-bin saturating hit counter, cleared when the result is taken
      always_ff @(posedge clk) begin
        if (rst || w_out_hs) begin
          r_cnt <= '0;
        end else if (w_hit && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_hist[gi] = r_cnt;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: close on length or flush, scan all bins, wait for handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACC:  if (flush || w_len_hit) w_state_next = ST_SCAN;
      ST_SCAN: if (w_scan_done) w_state_next = ST_OUT;
      ST_OUT:  if (out_ready) w_state_next = ST_ACC;
      default: w_state_next = ST_ACC;
    endcase
  end

  // Frame counting, sequential peak scan and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm_cnt   <= '0;
      r_sat       <= 1'b0;
      r_idx       <= '0;
      r_best      <= '0;
      r_best_bin  <= '0;
      r_peak_bin  <= '0;
      r_peak_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          // Scan always starts from bin 0 with an empty best
          r_idx      <= '0;
          r_best     <= '0;
          r_best_bin <= '0;
          if (w_accept) begin
            r_frm_cnt <= w_frm_inc;
          end
          if (w_hit_sat) begin
            r_sat <= 1'b1;
          end
        end
        ST_SCAN: begin
          r_idx      <= r_idx + 1'b1;
          r_best     <= w_best_cnt;
          r_best_bin <= w_best_bin;
          if (w_scan_done) begin
            r_peak_bin  <= w_best_bin;
            r_peak_cnt  <= w_best_cnt;
            r_frame_cnt <= r_frm_cnt;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_frm_cnt <= '0;
            r_sat     <= 1'b0;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign peak_bin  = r_peak_bin;
  assign peak_cnt  = r_peak_cnt;
  assign frame_cnt = r_frame_cnt;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_tdc_hist_peak.sv
// Scoreboard bench for tdc_hist_peak. Small counter widths are used so that
// bin and frame saturation are reachable in short frames.
module tb_tdc_hist_peak;

  localparam int BIN_W = 4;
  localparam int CNT_W = 3;
  localparam int FRM_W = 5;
  localparam int NBINS = 16;
  localparam int CMAX  = 7;
  localparam int FMAX  = 31;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             flush;
  logic [FRM_W-1:0] frame_len;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] peak_bin;
  logic [CNT_W-1:0] peak_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic             sat_flag;

  tdc_hist_peak #(.BIN_W(BIN_W), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .flush(flush), .frame_len(frame_len),
    .out_valid(out_valid), .out_ready(out_ready), .peak_bin(peak_bin),
    .peak_cnt(peak_cnt), .frame_cnt(frame_cnt), .sat_flag(sat_flag)
  );

  typedef struct {
    int bin;
    int cnt;
    int frm;
    int sat;
    int rise;
  } exp_t;

  exp_t sb[$];
  int   sbins[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold = 0;
  int   last_edge = 0;
  int   nres = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream ready: random, or forced low while hold is non-zero
  always @(posedge clk) begin
    #1;
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, stability under back-pressure and result values
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [BIN_W+CNT_W+FRM_W:0] snap;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out out_valid=1 required 0 at cycle %0d", cyc);
          end else if (cyc != sb[0].rise) begin
            errors++;
            $display("FAIL latency out_valid rose at cycle %0d required %0d", cyc, sb[0].rise);
          end
          snap = {peak_bin, peak_cnt, frame_cnt, sat_flag};
        end else begin
          checks++;
          if ({peak_bin, peak_cnt, frame_cnt, sat_flag} != snap) begin
            errors++;
            $display("FAIL hold_stable got %h required %h", {peak_bin, peak_cnt, frame_cnt, sat_flag}, snap);
          end
        end
        if (out_ready && sb.size() > 0) begin
          checks += 4;
          if (int'(peak_bin) != sb[0].bin) begin
            errors++;
            $display("FAIL peak_bin got %0d required %0d", peak_bin, sb[0].bin);
          end
          if (int'(peak_cnt) != sb[0].cnt) begin
            errors++;
            $display("FAIL peak_cnt got %0d required %0d", peak_cnt, sb[0].cnt);
          end
          if (int'(frame_cnt) != sb[0].frm) begin
            errors++;
            $display("FAIL frame_cnt got %0d required %0d", frame_cnt, sb[0].frm);
          end
          if (int'(sat_flag) != sb[0].sat) begin
            errors++;
            $display("FAIL sat_flag got %0d required %0d", sat_flag, sb[0].sat);
          end
          nres++;
          $display("result %0d: bin=%0d cnt=%0d frm=%0d sat=%0d (model %0d/%0d/%0d/%0d)",
                   nres, peak_bin, peak_cnt, frame_cnt, sat_flag,
                   sb[0].bin, sb[0].cnt, sb[0].frm, sb[0].sat);
          void'(sb.pop_front());
        end
      end else if (prev_v && !prev_r) begin
        checks++;
        errors++;
        $display("FAIL dropped_valid out_valid=0 without out_ready, required 1");
      end
      prev_v = out_valid;
      prev_r = out_ready;
    end
  end

  // Present one input beat and wait until the DUT takes it
  task automatic drive(input bit v, input int b, input int fl, input bit f);
    int t;
    t = 0;
    in_valid  = v;
    in_bin    = b[BIN_W-1:0];
    frame_len = fl[FRM_W-1:0];
    flush     = f;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=0 required 1 after %0d cycles", t);
    end
    @(posedge clk);
    #1;
    last_edge = cyc;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Play sbins as one frame; mode 0 = close by count, 1 = flush with last
  // sample, 2 = separate flush. The model is pushed when expect_out is set.
  task automatic run_frame(input int flen, input int mode, input bit expect_out);
    int   counts[NBINS];
    int   n;
    int   best;
    int   bb;
    int   sat;
    exp_t e;
    n = sbins.size();
    foreach (counts[i]) counts[i] = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
      drive(1'b1, sbins[i], flen, (mode == 1) && (i == n - 1));
      counts[sbins[i]]++;
    end
    if (mode == 2) drive(1'b0, 0, flen, 1'b1);
    best = 0;
    bb = 0;
    sat = 0;
    for (int i = 0; i < NBINS; i++) begin
      if (counts[i] > CMAX) sat = 1;
      if ((counts[i] > CMAX ? CMAX : counts[i]) > best) begin
        best = (counts[i] > CMAX) ? CMAX : counts[i];
        bb = i;
      end
    end
    if (expect_out) begin
      e.bin  = bb;
      e.cnt  = best;
      e.frm  = (n > FMAX) ? FMAX : n;
      e.sat  = sat;
      e.rise = last_edge + NBINS;
      sb.push_back(e);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL closed_ready in_ready=%0b required 0 after frame close", in_ready);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    int n;
    int mode;
    int flen;
    int hot;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bin = '0;
    flush = 1'b0;
    frame_len = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, peak_bin, peak_cnt, frame_cnt, sat_flag} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h required 0",
               {in_ready, out_valid, peak_bin, peak_cnt, frame_cnt, sat_flag});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);

    // Close by count
    sbins = '{3, 3, 3, 7, 7, 1, 3, 0, 7, 3};
    run_frame(10, 0, 1'b1);
    wait_drain();
    // Tie goes to the lowest index
    sbins = '{9, 5, 9, 5};
    run_frame(4, 0, 1'b1);
    wait_drain();
    // Flush with the last sample and long back-pressure
    sbins = '{12, 12, 12, 12};
    hold = 40;
    run_frame(0, 1, 1'b1);
    wait_drain();
    // Bin saturation
    sbins = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    run_frame(0, 2, 1'b1);
    wait_drain();
    // Empty flush
    sbins = {};
    run_frame(0, 2, 1'b1);
    wait_drain();
    // Frame counter saturation, closed by flush
    sbins = {};
    for (int i = 0; i < 40; i++) sbins.push_back(int'($urandom_range(0, 15)));
    run_frame(0, 2, 1'b1);
    wait_drain();
    // Frame length at its maximum
    sbins = {};
    for (int i = 0; i < FMAX; i++) sbins.push_back(int'($urandom_range(4, 7)));
    run_frame(FMAX, 0, 1'b1);
    wait_drain();

    // Reset during SCAN discards the frame
    sbins = '{6, 6, 6};
    run_frame(0, 2, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset in_ready=%0b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_midscan_reset in_ready=%0b required 1", in_ready);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_partial_result out_valid=%0b required 0", out_valid);
    end
    @(posedge clk);
    sbins = '{1, 6, 1};
    run_frame(3, 0, 1'b1);
    wait_drain();

    // Random frames
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 14);
      mode = $urandom_range(0, 2);
      hot = $urandom_range(0, 15);
      sbins = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) sbins.push_back(hot);
        else sbins.push_back(int'($urandom_range(0, 15)));
      end
      if (mode == 0) flen = n;
      else if ($urandom_range(0, 1) == 0) flen = 0;
      else flen = $urandom_range(n + 1, FMAX);
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(18, 30);
      run_frame(flen, mode, 1'b1);
      if ($urandom_range(0, 1) == 0) wait_drain();
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
